// File: rtl/ntt_iter_core.sv
// ntt_iter_core: iterative radix-2 NTT / inverse NTT over Z_q.
// One butterfly datapath works in place on an N-entry coefficient buffer.
// Coefficients are loaded bit-reversed, transformed with decimation-in-time
// stages, optionally scaled by N^-1, and streamed out in natural order.
//
// Ports:
//   clk        rising-edge clock
//   r          synchronous active-high reset (aborts any frame in flight)
//   mode_in    0 = forward, 1 = inverse; taken from the first beat of a frame
//   in_valid / in_ready / in_data     input coefficient stream (W bits)
//   out_valid / out_ready / out_data  output coefficient stream (W bits)
//   out_last   marks output beat N-1
//   busy       a frame is being loaded, computed or drained
module ntt_iter_core #(
  parameter int LOG_N     = 3,
  parameter int W         = 12,
  parameter int Q         = 3329,
  parameter int OMEGA     = 2580,
  parameter int OMEGA_INV = 40,
  parameter int N_INV     = 2913
) (
  input  logic         clk,
  input  logic         r,
  input  logic         mode_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int N  = 1 << LOG_N;
  localparam int HN = N / 2;
  localparam logic [W-1:0] QW     = W'(Q);
  localparam logic [W-1:0] NINV_W = W'(N_INV);
  // Barrett constant floor(2^(2W)/Q); fits W+1 bits because Q > 2^(W-1).
  localparam logic [W:0]   BM     = (W+1)'((64'd1 << (2*W)) / 64'(Q));

  // Twiddle tables: base^0 .. base^(N/2-1), built at elaboration.
  function automatic logic [HN-1:0][W-1:0] gen_tw(input longint unsigned base);
    logic [HN-1:0][W-1:0] t;
    longint unsigned acc;
    t   = '0;
    acc = 1;
    for (int i = 0; i < HN; i++) begin
      t[i] = W'(acc);
      acc  = (acc * base) % longint'(Q);
    end
    return t;
  endfunction

  localparam logic [HN-1:0][W-1:0] TW_F = gen_tw(longint'(OMEGA));
  localparam logic [HN-1:0][W-1:0] TW_I = gen_tw(longint'(OMEGA_INV));

  function automatic logic [W-1:0] add_q(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[W-1:0];
  endfunction

  // a - b + Q wraps mod 2^W to the right answer whenever the true result < Q.
  function automatic logic [W-1:0] sub_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? (a - b) : (a - b + QW);
  endfunction

  // Barrett: qh never overshoots floor(x/Q) and undershoots by at most one,
  // so a single conditional subtract completes the reduction.
  function automatic logic [W-1:0] mul_q(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] x, rr;
    logic [3*W:0]   xm;
    logic [W:0]     qh;
    x  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    xm = {{(W+1){1'b0}}, x} * {{(2*W){1'b0}}, BM};
    qh = xm[3*W:2*W];
    rr = x - ({{(W-1){1'b0}}, qh} * {{W{1'b0}}, QW});
    if (rr >= {{W{1'b0}}, QW}) rr = rr - {{W{1'b0}}, QW};
    return rr[W-1:0];
  endfunction

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] o;
    for (int i = 0; i < LOG_N; i++) o[i] = v[LOG_N-1-i];
    return o;
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, SCALE, UNLOAD} state_e;
  state_e state_q, state_d;

  logic [W-1:0]     mem_q [N];
  logic [LOG_N-1:0] cnt_q;      // load index j / scale index / unload index k
  logic [LOG_N-2:0] bf_q;       // butterfly within stage
  logic [2:0]       stg_q;      // stage
  logic             ph_q;       // 0 = read pair, 1 = write pair
  logic             mode_q;
  logic             init_q;     // holds in_ready low for one cycle after reset
  logic             vld_q;
  logic [W-1:0]     a_q, t_q;

  logic [LOG_N-1:0] bfx, half, lmask, i0, i1, twx;
  logic [W-1:0]     tw, in_red;
  logic             rdy, in_hs, out_hs, last_cnt, last_bf, last_stg;

  // Butterfly addressing for stage s: span 2^s, group stride 2^(s+1),
  // twiddle exponent p * N / 2^(s+1).
  always_comb begin
    bfx   = {1'b0, bf_q};
    half  = LOG_N'(1) << stg_q;
    lmask = half - LOG_N'(1);
    i0    = ((bfx & ~lmask) << 1) | (bfx & lmask);
    i1    = i0 | half;
    twx   = (bfx & lmask) << (3'(LOG_N-1) - stg_q);
    tw    = mode_q ? TW_I[twx[LOG_N-2:0]] : TW_F[twx[LOG_N-2:0]];
  end

  assign in_red   = (in_data >= QW) ? (in_data - QW) : in_data;
  assign last_cnt = (cnt_q == LOG_N'(N-1));
  assign last_bf  = (bf_q == (LOG_N-1)'(HN-1));
  assign last_stg = (stg_q == 3'(LOG_N-1));
  assign rdy      = (state_q == LOAD) && !init_q;
  assign in_hs    = rdy && in_valid;
  assign out_hs   = vld_q && out_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD:    if (in_hs && last_cnt) state_d = COMPUTE;
      COMPUTE: if (ph_q && last_bf && last_stg) state_d = mode_q ? SCALE : UNLOAD;
      SCALE:   if (last_cnt) state_d = UNLOAD;
      UNLOAD:  if (out_hs && last_cnt) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    // Outputs are forced quiet for the whole reset cycle, whatever the state.
    if (!r) begin
      in_ready  = rdy;
      out_valid = vld_q;
      out_last  = vld_q && last_cnt;
      out_data  = vld_q ? mem_q[cnt_q] : '0;
      busy      = (state_q != LOAD) || (cnt_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      bf_q    <= '0;
      stg_q   <= '0;
      ph_q    <= 1'b0;
      mode_q  <= 1'b0;
      init_q  <= 1'b1;
      vld_q   <= 1'b0;
      a_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b0;
      unique case (state_q)
        LOAD: if (in_hs) begin
          if (cnt_q == '0) mode_q <= mode_in;
          cnt_q <= cnt_q + LOG_N'(1);
        end
        COMPUTE: begin
          ph_q <= ~ph_q;
          if (!ph_q) begin
            a_q <= mem_q[i0];
            t_q <= mul_q(mem_q[i1], tw);
          end else if (last_bf) begin
            bf_q  <= '0;
            stg_q <= last_stg ? 3'd0 : stg_q + 3'd1;
          end else begin
            bf_q <= bf_q + (LOG_N-1)'(1);
          end
        end
        SCALE: cnt_q <= cnt_q + LOG_N'(1);
        // One idle cycle on entry presents the first element, then each
        // handshake advances k; cnt wraps back to 0 on the last beat.
        UNLOAD: begin
          if (!vld_q) vld_q <= 1'b1;
          else if (out_hs) begin
            cnt_q <= cnt_q + LOG_N'(1);
            if (last_cnt) vld_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient buffer: no reset, contents are meaningless between frames.
  always_ff @(posedge clk) begin
    if (!r) begin
      unique case (state_q)
        LOAD:    if (in_hs) mem_q[bitrev(cnt_q)] <= in_red;
        COMPUTE: if (ph_q) begin
          mem_q[i0] <= add_q(a_q, t_q);
          mem_q[i1] <= sub_q(a_q, t_q);
        end
        SCALE:   mem_q[cnt_q] <= mul_q(mem_q[cnt_q], NINV_W);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_iter_core.sv
// Bench for ntt_iter_core: directed vectors on an N=8 instance and random
// forward/inverse round trips on N=8 and N=16 instances. Drivers push the
// expected output beats into per-instance queues; monitors pop and compare.
module tb_ntt_iter_core;
  localparam int W = 12;
  localparam int Q = 3329;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  logic r3, md3, iv3, ir3, ov3, ordy3, ol3, busy3;
  logic [W-1:0] id3, od3;
  logic r4, md4, iv4, ir4, ov4, ordy4, ol4, busy4;
  logic [W-1:0] id4, od4;
  logic stall_en = 1'b0;

  ntt_iter_core #(.LOG_N(3)) u3 (
    .clk(clk), .r(r3), .mode_in(md3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_last(ol3), .busy(busy3));

  ntt_iter_core #(.LOG_N(4), .OMEGA(2642), .OMEGA_INV(2481), .N_INV(3121)) u4 (
    .clk(clk), .r(r4), .mode_in(md4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_last(ol4), .busy(busy4));

  logic [W:0] exp3_q[$], exp4_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (t=%0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ordy3 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard for the N=8 instance, plus stream-protocol checks.
  logic p_stall = 1'b0, p_ol = 1'b0, p_lasths = 1'b0;
  logic [W-1:0] p_od = '0;
  always @(negedge clk) begin
    logic [W:0] e;
    if (r3) begin
      p_stall = 1'b0; p_lasths = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_valid", int'(ov3), 1);
        chk("hold_data", int'(od3), int'(p_od));
        chk("hold_last", int'(ol3), int'(p_ol));
      end
      if (p_lasths) chk("ready_after_last", int'(ir3), 1);
      if (ov3) chk("ready_low_unload", int'(ir3), 0);
      if (ov3 && ordy3) begin
        if (exp3_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb3_unexpected got=%0d want=none", od3);
        end else begin
          e = exp3_q.pop_front();
          chk("sb3_data", int'(od3), int'(e[W-1:0]));
          chk("sb3_last", int'(ol3), int'(e[W]));
        end
      end
      p_stall  = ov3 && !ordy3;
      p_od     = od3;
      p_ol     = ol3;
      p_lasths = ov3 && ordy3 && ol3;
    end
  end

  always @(negedge clk) begin
    logic [W:0] e;
    if (!r4 && ov4 && ordy4) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb4_unexpected got=%0d want=none", od4);
      end else begin
        e = exp4_q.pop_front();
        chk("sb4_data", int'(od4), int'(e[W-1:0]));
        chk("sb4_last", int'(ol4), int'(e[W]));
      end
    end
  end

  function automatic longint pw(input longint b, input int e);
    longint acc = 1;
    for (int i = 0; i < e; i++) acc = (acc * b) % Q;
    return acc;
  endfunction

  // Direct O(N^2) transform sum used as the reference.
  task automatic dft(input int n, input int w, input int x[16], output int y[16]);
    for (int k = 0; k < 16; k++) y[k] = 0;
    for (int k = 0; k < n; k++) begin
      longint acc = 0;
      for (int j = 0; j < n; j++) acc = (acc + longint'(x[j]) * pw(w, (j * k) % n)) % Q;
      y[k] = int'(acc);
    end
  endtask

  // Stream one frame in; mode_in is inverted after beat 0 to show it is
  // only sampled on the first beat. hs = cycle of the last handshake.
  task automatic send(input int inst, input bit m, input int x[16], input int ex[16],
                      input bit push, output int hs);
    int n = (inst == 3) ? 8 : 16;
    bit got;
    hs = 0;
    if (push)
      for (int k = 0; k < n; k++)
        if (inst == 3) exp3_q.push_back({k == n - 1, W'(ex[k])});
        else           exp4_q.push_back({k == n - 1, W'(ex[k])});
    @(posedge clk); #1;
    for (int j = 0; j < n; j++) begin
      if (inst == 3) begin iv3 = 1'b1; id3 = W'(x[j]); md3 = (j == 0) ? m : ~m; end
      else           begin iv4 = 1'b1; id4 = W'(x[j]); md4 = (j == 0) ? m : ~m; end
      got = 1'b0;
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        if ((inst == 3) ? ir3 : ir4) begin got = 1'b1; hs = cyc; end
        else @(posedge clk);
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout inst=%0d beat=%0d", inst, j);
      end
      @(posedge clk); #1;
    end
    if (inst == 3) iv3 = 1'b0; else iv4 = 1'b0;
  endtask

  task automatic lat3(input int hs, input int want);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (ov3) break;
    end
    chk("latency", cyc - hs, want);
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && (exp3_q.size() != 0 || exp4_q.size() != 0); t++) @(negedge clk);
  endtask

  task automatic rst_chk(input int want_ir);
    chk("rst_in_ready", int'(ir3), want_ir);
    chk("rst_out_valid", int'(ov3), 0);
    chk("rst_out_last", int'(ol3), 0);
    chk("rst_busy", int'(busy3), 0);
    chk("rst_out_data", int'(od3), 0);
  endtask

  task automatic round_trips(input int inst);
    int n = (inst == 3) ? 8 : 16;
    int w = (inst == 3) ? 2580 : 2642;
    int x[16], y[16];
    int hs;
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 16; j++) x[j] = (j < n) ? int'($urandom_range(0, Q - 1)) : 0;
      dft(n, w, x, y);
      send(inst, 1'b0, x, y, 1'b1, hs);
      send(inst, 1'b1, y, x, 1'b1, hs);
    end
  endtask

  int imp[16]  = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  int ones[16] = '{1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0};
  int sh[16]   = '{0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  int fs[16]   = '{1,2580,1729,3289,3328,749,1600,40, 0,0,0,0,0,0,0,0};
  int big[16]  = '{4095,4095,4095,4095,4095,4095,4095,4095, 0,0,0,0,0,0,0,0};
  int bigx[16] = '{2799,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};

  initial begin
    int hs;
    r3 = 1'b1; r4 = 1'b1; iv3 = 1'b0; iv4 = 1'b0; md3 = 1'b0; md4 = 1'b0;
    id3 = '0; id4 = '0; ordy4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_chk(0);
    @(posedge clk); #1; r3 = 1'b0; r4 = 1'b0;
    @(negedge clk); rst_chk(0);
    @(negedge clk); chk("ready_after_reset", int'(ir3), 1);

    send(3, 1'b0, imp, ones, 1'b1, hs);   drain();
    send(3, 1'b0, sh, fs, 1'b1, hs);      lat3(hs, 26); drain();
    send(3, 1'b1, fs, sh, 1'b1, hs);      lat3(hs, 34); drain();
    send(3, 1'b1, ones, imp, 1'b1, hs);   drain();
    send(3, 1'b0, big, bigx, 1'b1, hs);   drain();

    stall_en = 1'b1;
    send(3, 1'b0, sh, fs, 1'b1, hs);      drain();
    stall_en = 1'b0;

    // Abort a frame mid-COMPUTE; nothing from it may reach the output.
    send(3, 1'b0, sh, fs, 1'b0, hs);
    repeat (5) @(posedge clk);
    #1; r3 = 1'b1;
    @(negedge clk); rst_chk(0);
    @(posedge clk); #1; r3 = 1'b0;
    @(negedge clk); rst_chk(0);
    @(negedge clk); chk("ready_after_abort", int'(ir3), 1);
    send(3, 1'b0, imp, ones, 1'b1, hs);   drain();

    fork
      round_trips(3);
      round_trips(4);
    join
    drain();
    chk("sb_drain", exp3_q.size() + exp4_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
